// File: rtl/hwpe_ctrl_uloop_dispatch_pkg.sv
// Shared types for the micro-loop dispatcher: FSM state encoding and the
// descriptor record handed to the streamer control path.
// Ports: none (package only).
package hwpe_ctrl_package;

    localparam int unsigned ULOOP_NB_REG     = 4;
    localparam int unsigned ULOOP_REG_WIDTH  = 32;
    localparam int unsigned ULOOP_NB_LOOPS   = 6;
    localparam int unsigned ULOOP_CNT_WIDTH  = 16;
    localparam int unsigned ULOOP_NB_STREAMS = 4;
    localparam int unsigned ULOOP_ADDR_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        ISSUE,
        REQ,
        WAIT,
        FINISH
    } dispatch_state_t;

    typedef struct packed {
        logic [ULOOP_NB_STREAMS*ULOOP_ADDR_WIDTH-1:0] addr;
        logic [ULOOP_NB_LOOPS*ULOOP_CNT_WIDTH-1:0]    idx;
        logic                                         last;
    } uloop_desc_t;

endpackage

// File: rtl/hwpe_ctrl_uloop_dispatch_addr.sv
// Per-stream address generator: selects one engine offset register per stream
// and adds it to that stream's base address (modulo 2^ADDR_WIDTH).
// Latency: combinational. Backpressure: none.
// Ports: base_i (per-stream base), offs_i (engine offsets), map_i (register
// select per stream), addr_o (per-stream sum).
module hwpe_ctrl_uloop_dispatch_addr #(
    parameter int unsigned NB_REG     = 4,
    parameter int unsigned REG_WIDTH  = 32,
    parameter int unsigned NB_STREAMS = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned MAP_W      = 2
) (
    input  logic [NB_STREAMS*ADDR_WIDTH-1:0] base_i,
    input  logic [NB_REG*REG_WIDTH-1:0]      offs_i,
    input  logic [NB_STREAMS*MAP_W-1:0]      map_i,
    output logic [NB_STREAMS*ADDR_WIDTH-1:0] addr_o
);

    logic [REG_WIDTH-1:0] offs_arr [NB_REG];

    for (genvar r = 0; r < NB_REG; r++) begin : g_reg
        assign offs_arr[r] = offs_i[r*REG_WIDTH +: REG_WIDTH];
    end

    for (genvar s = 0; s < NB_STREAMS; s++) begin : g_stream
        logic [MAP_W-1:0]      sel;
        logic [REG_WIDTH-1:0]  off;
        logic [ADDR_WIDTH-1:0] off_ext;

        assign sel = map_i[s*MAP_W +: MAP_W];
        assign off = offs_arr[sel];

        // Offset is truncated or zero-extended to the address width.
        if (REG_WIDTH >= ADDR_WIDTH) begin : g_trunc
            assign off_ext = off[ADDR_WIDTH-1:0];
        end else begin : g_zext
            assign off_ext = {{(ADDR_WIDTH-REG_WIDTH){1'b0}}, off};
        end

        assign addr_o[s*ADDR_WIDTH +: ADDR_WIDTH] = base_i[s*ADDR_WIDTH +: ADDR_WIDTH] + off_ext;
    end

endmodule

// File: rtl/hwpe_ctrl_uloop_dispatch.sv
// Micro-loop dispatcher: steps the shadowed uloop engine once per iteration and
// issues one per-stream address descriptor per iteration; flags end of job and
// engine/count mismatch. First descriptor 2 cycles after start; serial mode
// needs 3 cycles per descriptor, prefetch mode down to 1.
// Backpressure: desc_valid_o/desc_ready_i; descriptor held stable until taken.
// Optional: HWPE_CTRL_ULOOP_DISPATCH_PREFETCH_EN adds a one-entry staging
// register so the next engine step overlaps the wait for desc_ready_i.
// Ports: clk_i/rst_ni/clear_i; job config (start_i, total_iter_i, base_addr_i,
// stream_map_i); engine side (uloop_*); descriptor side (desc_*); status
// (busy_o, done_o, err_o).
module hwpe_ctrl_uloop_dispatch
    import hwpe_ctrl_package::*;
#(
    parameter int unsigned NB_REG     = ULOOP_NB_REG,
    parameter int unsigned REG_WIDTH  = ULOOP_REG_WIDTH,
    parameter int unsigned NB_LOOPS   = ULOOP_NB_LOOPS,
    parameter int unsigned CNT_WIDTH  = ULOOP_CNT_WIDTH,
    parameter int unsigned NB_STREAMS = ULOOP_NB_STREAMS,
    parameter int unsigned ADDR_WIDTH = ULOOP_ADDR_WIDTH,
    parameter int unsigned MAP_W      = (NB_REG > 1) ? $clog2(NB_REG) : 1
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           clear_i,
    input  logic                           start_i,
    input  logic [31:0]                    total_iter_i,
    input  logic [NB_STREAMS*ADDR_WIDTH-1:0] base_addr_i,
    input  logic [NB_STREAMS*MAP_W-1:0]    stream_map_i,
    output logic                           uloop_clear_o,
    output logic                           uloop_enable_o,
    input  logic                           uloop_ready_i,
    input  logic                           uloop_valid_i,
    input  logic                           uloop_done_i,
    input  logic [NB_REG*REG_WIDTH-1:0]    uloop_offs_i,
    input  logic [NB_LOOPS*CNT_WIDTH-1:0]  uloop_idx_i,
    output logic                           desc_valid_o,
    input  logic                           desc_ready_i,
    output logic [NB_STREAMS*ADDR_WIDTH-1:0] desc_addr_o,
    output logic [NB_LOOPS*CNT_WIDTH-1:0]  desc_idx_o,
    output logic                           desc_last_o,
    output logic                           busy_o,
    output logic                           done_o,
    output logic                           err_o
);

    dispatch_state_t                 state_q;
    uloop_desc_t                     desc_q, new_desc;
    logic                            desc_vld_q, clr_q, done_q, err_q;
    logic [31:0]                     cnt_q, total_q;
    logic [NB_STREAMS*ADDR_WIDTH-1:0] base_q, sum_addr;
    logic [NB_STREAMS*MAP_W-1:0]     map_q;
    logic                            hs, new_last, enable;

    hwpe_ctrl_uloop_dispatch_addr #(
        .NB_REG    (NB_REG),
        .REG_WIDTH (REG_WIDTH),
        .NB_STREAMS(NB_STREAMS),
        .ADDR_WIDTH(ADDR_WIDTH),
        .MAP_W     (MAP_W)
    ) i_addr (
        .base_i(base_q),
        .offs_i(uloop_offs_i),
        .map_i (map_q),
        .addr_o(sum_addr)
    );

    assign hs = desc_vld_q & desc_ready_i;
    // The engine result always belongs to descriptor number cnt_q+1.
    assign new_last = (cnt_q + 32'd1) == (total_q - 32'd1);

    always_comb begin
        new_desc      = '0;
        new_desc.addr = sum_addr;
        new_desc.idx  = uloop_idx_i;
        new_desc.last = new_last;
    end

`ifdef HWPE_CTRL_ULOOP_DISPATCH_PREFETCH_EN
    uloop_desc_t stage_q;
    logic        stage_vld_q, req_q, pf_en;
    // Prefetch the next step while the current descriptor waits; one request max.
    assign pf_en  = (state_q == ISSUE) && !desc_q.last && uloop_ready_i && !stage_vld_q && !req_q;
    assign enable = ((state_q == REQ) && uloop_ready_i) || pf_en;
`else
    assign enable = (state_q == REQ) && uloop_ready_i;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;  desc_q  <= '0;  desc_vld_q <= 1'b0;
            clr_q   <= 1'b0;  done_q  <= 1'b0; err_q     <= 1'b0;
            cnt_q   <= '0;    total_q <= '0;  base_q     <= '0;  map_q <= '0;
`ifdef HWPE_CTRL_ULOOP_DISPATCH_PREFETCH_EN
            stage_q <= '0;    stage_vld_q <= 1'b0; req_q <= 1'b0;
`endif
        end else if (clear_i) begin
            state_q <= IDLE;  desc_q  <= '0;  desc_vld_q <= 1'b0;
            clr_q   <= 1'b0;  done_q  <= 1'b0; err_q     <= 1'b0;
            cnt_q   <= '0;    total_q <= '0;  base_q     <= '0;  map_q <= '0;
`ifdef HWPE_CTRL_ULOOP_DISPATCH_PREFETCH_EN
            stage_q <= '0;    stage_vld_q <= 1'b0; req_q <= 1'b0;
`endif
        end else begin
            clr_q  <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        if (total_iter_i != 32'd0) begin
                            total_q <= total_iter_i;
                            base_q  <= base_addr_i;
                            map_q   <= stream_map_i;
                            clr_q   <= 1'b1;
                            state_q <= INIT;
                        end else begin
                            done_q  <= 1'b1;
                        end
                    end
                end
                INIT: begin
                    desc_q.addr <= base_q;
                    desc_q.idx  <= '0;
                    desc_q.last <= (total_q == 32'd1);
                    cnt_q       <= '0;
                    err_q       <= 1'b0;
                    desc_vld_q  <= 1'b1;
                    state_q     <= ISSUE;
                end
                ISSUE: begin
`ifdef HWPE_CTRL_ULOOP_DISPATCH_PREFETCH_EN
                    if (req_q && uloop_valid_i && !hs) begin
                        stage_q     <= new_desc;
                        stage_vld_q <= 1'b1;
                        req_q       <= 1'b0;
                        if (uloop_done_i && !new_last) err_q <= 1'b1;
                    end
                    if (pf_en) req_q <= 1'b1;
`endif
                    if (hs) begin
                        if (desc_q.last) begin
                            desc_vld_q <= 1'b0;
                            done_q     <= 1'b1;
                            state_q    <= FINISH;
                        end
`ifdef HWPE_CTRL_ULOOP_DISPATCH_PREFETCH_EN
                        else if (stage_vld_q) begin
                            desc_q      <= stage_q;
                            stage_vld_q <= 1'b0;
                            cnt_q       <= cnt_q + 32'd1;
                        end else if (req_q && uloop_valid_i) begin
                            // Result lands in the same cycle as the handshake.
                            desc_q <= new_desc;
                            req_q  <= 1'b0;
                            cnt_q  <= cnt_q + 32'd1;
                            if (uloop_done_i && !new_last) err_q <= 1'b1;
                        end else if (req_q || pf_en) begin
                            desc_vld_q <= 1'b0;
                            state_q    <= WAIT;
                        end
`endif
                        else begin
                            desc_vld_q <= 1'b0;
                            state_q    <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (uloop_ready_i) begin
                        state_q <= WAIT;
`ifdef HWPE_CTRL_ULOOP_DISPATCH_PREFETCH_EN
                        req_q   <= 1'b1;
`endif
                    end
                end
                WAIT: begin
                    if (uloop_valid_i) begin
                        desc_q     <= new_desc;
                        cnt_q      <= cnt_q + 32'd1;
                        desc_vld_q <= 1'b1;
                        state_q    <= ISSUE;
                        if (uloop_done_i && !new_last) err_q <= 1'b1;
`ifdef HWPE_CTRL_ULOOP_DISPATCH_PREFETCH_EN
                        req_q      <= 1'b0;
`endif
                    end
                end
                FINISH:  state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign uloop_clear_o  = clr_q;
    assign uloop_enable_o = enable;
    assign desc_valid_o   = desc_vld_q;
    assign desc_addr_o    = desc_q.addr;
    assign desc_idx_o     = desc_q.idx;
    assign desc_last_o    = desc_q.last;
    assign busy_o         = (state_q != IDLE);
    assign done_o         = done_q;
    assign err_o          = err_q;

endmodule

// File: tb/tb_hwpe_ctrl_uloop_dispatch.sv
// Bench for hwpe_ctrl_uloop_dispatch: a table of jobs run against a small
// uloop engine model, with a descriptor scoreboard, plus stall, clear and
// zero-length sequences.
module tb_hwpe_ctrl_uloop_dispatch;

`ifdef HWPE_CTRL_ULOOP_DISPATCH_PREFETCH_EN
    localparam int GAP = 2, STALL_GAP = 1, STALL_EN_MAX = 1;
`else
    localparam int GAP = 3, STALL_GAP = 3, STALL_EN_MAX = 0;
`endif

    logic         clk_i = 1'b0, rst_ni = 1'b0, clear_i = 1'b0, start_i = 1'b0;
    logic [31:0]  total_iter_i = '0;
    logic [127:0] base_addr_i = '0;
    logic [7:0]   stream_map_i = '0;
    logic         uloop_clear_o, uloop_enable_o;
    logic         uloop_ready_i = 1'b1, uloop_valid_i = 1'b0, uloop_done_i = 1'b0;
    logic [127:0] uloop_offs_i = '0;
    logic [95:0]  uloop_idx_i = '0;
    logic         desc_valid_o, desc_ready_i = 1'b0;
    logic [127:0] desc_addr_o;
    logic [95:0]  desc_idx_o;
    logic         desc_last_o, busy_o, done_o, err_o;

    hwpe_ctrl_uloop_dispatch dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i),
        .total_iter_i(total_iter_i), .base_addr_i(base_addr_i), .stream_map_i(stream_map_i),
        .uloop_clear_o(uloop_clear_o), .uloop_enable_o(uloop_enable_o),
        .uloop_ready_i(uloop_ready_i), .uloop_valid_i(uloop_valid_i), .uloop_done_i(uloop_done_i),
        .uloop_offs_i(uloop_offs_i), .uloop_idx_i(uloop_idx_i),
        .desc_valid_o(desc_valid_o), .desc_ready_i(desc_ready_i), .desc_addr_o(desc_addr_o),
        .desc_idx_o(desc_idx_o), .desc_last_o(desc_last_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int unsigned total;
        logic [31:0] base0;
        logic [1:0]  reg_sel;
        logic [31:0] stride;
        int unsigned done_at;
        logic [31:0] exp_last_addr;
        logic        exp_err;
    } job_t;

    typedef struct packed {
        logic [31:0] a0;
        logic [31:0] a1;
        logic        last;
        logic [15:0] idx0;
    } exp_t;

    job_t jobs [6];
    exp_t exp_q [$];

    int n_chk = 0, n_pass = 0;
    int cyc = 0;
    // engine model / stimulus knobs
    logic [1:0]  cur_reg = 2'd1;
    logic [31:0] cur_stride = 32'h10;
    int unsigned cur_done_at = 0;
    int unsigned k = 0;
    bit ready_en = 1'b0, en_prev = 1'b0, stall_now = 1'b0;
    int stall_idx = -1, stall_left = 0, stall_en = 0, en_cnt = 0;
    // monitor results
    int hs_cnt = 0, done_cnt = 0, max_gap = 0, done_cyc = 0, last_hs_cyc = 0, stable_bad = 0;
    int hs_cyc [16];
    logic [31:0]  last_addr = '0;
    logic [127:0] snap_addr;
    logic         snap_vld = 1'b0, prev_pending = 1'b0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] offs_of(input logic [1:0] r, input int unsigned n);
        return (r == cur_reg) ? n * cur_stride : n * 32'h4;
    endfunction

    // Engine and sink driver: result one cycle after each enable.
    initial forever begin
        @(negedge clk_i);
        if (en_prev) begin
            k = k + 1;
            uloop_valid_i = 1'b1;
            for (int r = 0; r < 4; r++) uloop_offs_i[r*32 +: 32] = offs_of(r[1:0], k);
            uloop_idx_i = '0;
            uloop_idx_i[15:0] = k[15:0];
            uloop_done_i = (cur_done_at != 0) && (k >= cur_done_at);
        end else begin
            uloop_valid_i = 1'b0;
        end
        stall_now = ready_en && desc_valid_o && (hs_cnt == stall_idx) && (stall_left > 0);
        if (stall_now) stall_left--;
        desc_ready_i = ready_en && !stall_now;
        #1;
        en_prev = uloop_enable_o;
        if (uloop_enable_o) begin
            en_cnt++;
            if (stall_now) stall_en++;
        end
        if (uloop_clear_o) begin
            k = 0; uloop_offs_i = '0; uloop_idx_i = '0; uloop_done_i = 1'b0;
        end
    end

    // Monitor: scoreboard on each handshake, stability while stalled.
    initial forever begin
        exp_t e;
        @(negedge clk_i);
        #2;
        if (done_o) begin done_cnt++; done_cyc = cyc; end
        if (prev_pending && !desc_valid_o && !clear_i) stable_bad++;
        if (desc_valid_o && !desc_ready_i) begin
            if (snap_vld && snap_addr !== desc_addr_o) stable_bad++;
            snap_addr = desc_addr_o;
            snap_vld  = 1'b1;
        end
        prev_pending = desc_valid_o && !desc_ready_i && !clear_i;
        if (desc_valid_o && desc_ready_i) begin
            snap_vld = 1'b0;
            if (hs_cnt > 0 && (cyc - last_hs_cyc) > max_gap) max_gap = cyc - last_hs_cyc;
            if (hs_cnt < 16) hs_cyc[hs_cnt] = cyc;
            last_hs_cyc = cyc;
            hs_cnt++;
            last_addr = desc_addr_o[31:0];
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL desc_extra: got addr %0h expected no descriptor", desc_addr_o[31:0]);
            end else begin
                e = exp_q.pop_front();
                check("desc", 128'({desc_addr_o[31:0], desc_addr_o[63:32], desc_last_o, desc_idx_o[15:0]}),
                      128'(e));
            end
        end
    end

    task automatic run_job(input job_t j, input int stall_at);
        exp_t e;
        bit got;
        cur_reg = j.reg_sel; cur_stride = j.stride; cur_done_at = j.done_at;
        for (int unsigned n = 0; n < j.total; n++) begin
            e.a0   = j.base0 + offs_of(j.reg_sel, n);
            e.a1   = 32'h100 + offs_of(2'd0, n);
            e.last = (n == j.total - 1);
            e.idx0 = n[15:0];
            exp_q.push_back(e);
        end
        @(negedge clk_i);
        hs_cnt = 0; done_cnt = 0; en_cnt = 0; max_gap = 0; stall_en = 0; stable_bad = 0;
        stall_idx = stall_at; stall_left = (stall_at >= 0) ? 5 : 0; ready_en = 1'b1;
        start_i = 1'b1; total_iter_i = j.total;
        base_addr_i = {32'h0, 32'h0, 32'h100, j.base0};
        stream_map_i = {6'd0, j.reg_sel};
        @(negedge clk_i);
        start_i = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 400 && !got; c++) begin
            @(negedge clk_i); #3;
            if (done_cnt != 0) got = 1'b1;
        end
        check("job_done_seen", 128'(got), 128'(1));
        check("done_latency", 128'(done_cyc - last_hs_cyc), 128'(1));
        @(negedge clk_i); #3;
        check("busy_after_done", 128'({busy_o, done_o}), 128'(0));
        repeat (2) @(negedge clk_i);
        #3;
        check("done_once", 128'(done_cnt), 128'(1));
        check("desc_count", 128'(hs_cnt), 128'(j.total));
        check("enable_count", 128'(en_cnt), 128'(j.total - 1));
        check("err", 128'(err_o), 128'(j.exp_err));
        check("last_addr", 128'(last_addr), 128'(j.exp_last_addr));
        check("sb_empty", 128'(exp_q.size()), 128'(0));
        if (stall_at < 0 && j.total > 1) check("hs_gap", 128'(max_gap), 128'(GAP));
        exp_q.delete();
    endtask

    initial begin
        bit got;
        jobs[0] = '{1, 32'h0000_1000, 2'd1, 32'h10,  0, 32'h0000_1000, 1'b0};
        jobs[1] = '{4, 32'h0000_1000, 2'd1, 32'h10,  0, 32'h0000_1030, 1'b0};
        jobs[2] = '{2, 32'hFFFF_FFF0, 2'd2, 32'h20,  0, 32'h0000_0010, 1'b0};
        jobs[3] = '{4, 32'h0000_2000, 2'd1, 32'h10,  2, 32'h0000_2030, 1'b1};
        jobs[4] = '{3, 32'h0000_4000, 2'd3, 32'h100, 0, 32'h0000_4200, 1'b0};
        jobs[5] = '{5, 32'h0000_8000, 2'd0, 32'h8,   0, 32'h0000_8020, 1'b0};

        repeat (3) @(negedge clk_i);
        #3;
        check("reset_outputs", 128'({uloop_clear_o, uloop_enable_o, desc_valid_o, desc_last_o,
              busy_o, done_o, err_o, desc_addr_o[31:0], desc_idx_o[15:0]}), 128'(0));
        rst_ni = 1'b1;
        @(negedge clk_i); #3;
        check("post_reset_idle", 128'({busy_o, desc_valid_o, done_o}), 128'(0));

        for (int i = 0; i < 6; i++) run_job(jobs[i], -1);

        // Sink holds off descriptor 1 for five cycles.
        run_job(jobs[1], 1);
        check("stall_stable", 128'(stable_bad), 128'(0));
        check("stall_enables", 128'(stall_en <= STALL_EN_MAX), 128'(1));
        check("stall_gap", 128'(hs_cyc[2] - hs_cyc[1]), 128'(STALL_GAP));

        // Clear while a descriptor is pending.
        @(negedge clk_i);
        ready_en = 1'b0; stall_idx = -1; hs_cnt = 0; done_cnt = 0;
        cur_reg = 2'd1; cur_stride = 32'h10; cur_done_at = 0;
        start_i = 1'b1; total_iter_i = 32'd4; base_addr_i = {96'h0, 32'h3000}; stream_map_i = 8'd1;
        @(negedge clk_i);
        start_i = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk_i); #3;
            if (desc_valid_o) got = 1'b1;
        end
        check("clr_pre_valid", 128'(got), 128'(1));
        @(negedge clk_i);
        clear_i = 1'b1;
        @(negedge clk_i);
        clear_i = 1'b0;
        #3;
        check("clr_outputs", 128'({uloop_clear_o, uloop_enable_o, desc_valid_o, desc_last_o, busy_o,
              done_o, err_o, desc_addr_o[63:0], desc_idx_o[31:0]}), 128'(0));
        repeat (6) @(negedge clk_i);
        #3;
        check("clr_no_done", 128'({done_cnt, hs_cnt}), 128'(0));
        check("clr_idle", 128'({busy_o, desc_valid_o}), 128'(0));

        // Zero-length job: done pulse only.
        @(negedge clk_i);
        start_i = 1'b1; total_iter_i = 32'd0;
        @(negedge clk_i);
        start_i = 1'b0;
        #3;
        check("zero_done", 128'({done_o, busy_o}), 128'(2'b10));
        @(negedge clk_i); #3;
        check("zero_done_pulse", 128'({done_o, busy_o, desc_valid_o}), 128'(0));

        // Normal job after clear.
        run_job(jobs[1], -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
